// File: rtl/cv32e40p_alu_fault_manager.sv
// Recovery controller for the triple-redundant EX-stage ALU: holds write-back on a voted
// fault, requests bounded replays, counts faults and escalates to fatal when retries run out.
module cv32e40p_alu_fault_manager #(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    input  logic                 ex_ready_i,
    input  logic                 alu_fault_i,
    input  logic                 clear_i,
    output logic                 fault_hold_o,
    output logic                 replay_o,
    output logic                 fault_irq_o,
    output logic                 fault_status_o,
    output logic                 fatal_o,
    output logic [CNT_WIDTH-1:0] fault_count_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REPLAY = 2'd1,
        S_WAIT   = 2'd2,
        S_FATAL  = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_retry_cnt;
    logic                 r_replay;
    logic                 r_irq;
    logic                 r_status;
    logic                 r_fatal;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_ev_fault;
    logic                 w_ev_ok;
    logic                 w_eval_state;
    logic                 w_count_en;
    logic                 w_cnt_max;
    logic [4:0]           w_retry_inc;
    logic [4:0]           w_retry_lim;
    logic                 w_retry_over;

    // Event qualification and retry-limit arithmetic
    always_comb begin
        w_ev_fault   = alu_valid_i & ex_ready_i & alu_fault_i;
        w_ev_ok      = alu_valid_i & ex_ready_i & ~alu_fault_i;
        w_eval_state = (r_state == S_IDLE) || (r_state == S_WAIT);
        w_count_en   = w_ev_fault & w_eval_state;
        w_cnt_max    = &r_count;
        // Five bits so that retry_cnt == 15 plus one cannot wrap back under the limit
        w_retry_inc  = {1'b0, r_retry_cnt} + 5'd1;
        w_retry_lim  = 5'(MAX_RETRY);
        w_retry_over = (w_retry_inc > w_retry_lim);
    end

    // Write-back hold follows the current state with zero latency
    always_comb begin
        if (w_ev_fault && w_eval_state) begin
            fault_hold_o = 1'b1;
        end else begin
            fault_hold_o = 1'b0;
        end
    end

    // Recovery FSM together with all registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_retry_cnt <= 4'd0;
            r_replay    <= 1'b0;
            r_irq       <= 1'b0;
            r_status    <= 1'b0;
            r_fatal     <= 1'b0;
            r_count     <= '0;
        end else if (clear_i) begin
            r_state     <= S_IDLE;
            r_retry_cnt <= 4'd0;
            r_replay    <= 1'b0;
            r_irq       <= 1'b0;
            r_status    <= 1'b0;
            r_fatal     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_replay <= 1'b0;
            r_irq    <= 1'b0;

            if (w_count_en) begin
                if (!w_cnt_max) begin
                    r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                r_status <= 1'b1;
                r_irq    <= ~r_status;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ev_fault) begin
                        r_retry_cnt <= 4'd1;
                        if (5'd1 > w_retry_lim) begin
                            r_state <= S_FATAL;
                            r_fatal <= 1'b1;
                        end else begin
                            r_state  <= S_REPLAY;
                            r_replay <= 1'b1;
                        end
                    end
                end
                S_REPLAY: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_ev_fault) begin
                        r_retry_cnt <= (w_retry_inc[4]) ? 4'hF : w_retry_inc[3:0];
                        if (w_retry_over) begin
                            r_state <= S_FATAL;
                            r_fatal <= 1'b1;
                        end else begin
                            r_state  <= S_REPLAY;
                            r_replay <= 1'b1;
                        end
                    end else if (w_ev_ok) begin
                        r_state     <= S_IDLE;
                        r_retry_cnt <= 4'd0;
                    end
                end
                S_FATAL: begin
                    r_state <= S_FATAL;
                    r_fatal <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_retry_cnt <= 4'd0;
                    r_fatal     <= 1'b0;
                end
            endcase
        end
    end

    assign replay_o       = r_replay;
    assign fault_irq_o    = r_irq;
    assign fault_status_o = r_status;
    assign fatal_o        = r_fatal;
    assign fault_count_o  = r_count;

endmodule
